// File: rtl/clock_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl_if : button, time-datapath and display bundle for clock_mode_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface clock_mode_ctrl_if;
  logic       btnC;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic [5:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       run_en;
  logic       load;
  logic [5:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_armed;
  logic       ringing;
  logic [1:0] mode;
  logic       field;
  logic       blink;

  modport master (
    output btnC, btnU, btnD, btnL, btnR, cur_hour, cur_min, cur_sec,
    input  run_en, load, set_hour, set_min, alarm_hour, alarm_min,
           alarm_armed, ringing, mode, field, blink
  );

  modport slave (
    input  btnC, btnU, btnD, btnL, btnR, cur_hour, cur_min, cur_sec,
    output run_en, load, set_hour, set_min, alarm_hour, alarm_min,
           alarm_armed, ringing, mode, field, blink
  );
endinterface

`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl : mode/sequencing controller for the digital clock datapath.
// Optional macro SNOOZE_EN: U in RING snoozes the alarm by SNOOZE_MIN minutes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clock_mode_ctrl #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int TIMEOUT_SEC = 30,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic             clk,
  input  logic             rst,
  clock_mode_ctrl_if.slave bus
);

  localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLINK_TC = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
  localparam int BW       = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;
  localparam int TW       = $clog2(TIMEOUT_SEC + 1);
  localparam int RW       = $clog2(RING_SEC + 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_EDIT_TIME  = 2'd1,
    ST_EDIT_ALARM = 2'd2,
    ST_RING       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    btn_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [5:0]    buf_hour_q, buf_hour_d, buf_min_q, buf_min_d;
  logic [5:0]    alarm_hour_q, alarm_hour_d, alarm_min_q, alarm_min_d;
  logic          armed_q, armed_d;
  logic          field_q, field_d;
  logic          load_q, load_d;
  logic          run_en_q, run_en_d;
  logic          match_q, match_d;

  logic [4:0] btn, edges;
  logic       act_c, act_u, act_d, act_l, act_r, any_edge;
  logic       sec_pulse, blink_tick, match_rise;

  // Button order {C,U,D,L,R}; only the highest-priority edge acts.
  assign btn      = {bus.btnC, bus.btnU, bus.btnD, bus.btnL, bus.btnR};
  assign edges    = btn & ~btn_prev_q;
  assign any_edge = |edges;
  assign act_c    = edges[4];
  assign act_u    = edges[3] & ~edges[4];
  assign act_d    = edges[2] & ~(|edges[4:3]);
  assign act_l    = edges[1] & ~(|edges[4:2]);
  assign act_r    = edges[0] & ~(|edges[4:1]);

  assign sec_pulse  = (presc_q == PW'(CLK_HZ - 1));
  assign blink_tick = (blink_cnt_q == BW'(BLINK_TC - 1));

  assign match_d    = armed_q && (bus.cur_hour == alarm_hour_q) &&
                      (bus.cur_min == alarm_min_q) && (bus.cur_sec == 6'd0);
  assign match_rise = match_d & ~match_q;

`ifdef SNOOZE_EN
  logic [6:0] snz_sum;
  assign snz_sum = {1'b0, alarm_min_q} + 7'(SNOOZE_MIN);
`endif

  always_comb begin
    state_d      = state_q;
    buf_hour_d   = buf_hour_q;
    buf_min_d    = buf_min_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    armed_d      = armed_q;
    field_d      = field_q;
    load_d       = 1'b0;
    tmo_d        = tmo_q;
    ring_cnt_d   = ring_cnt_q;
    presc_d      = sec_pulse ? '0 : presc_q + 1'b1;
    blink_cnt_d  = blink_tick ? '0 : blink_cnt_q + 1'b1;

    case (state_q)
      ST_RUN: begin
        tmo_d      = '0;
        ring_cnt_d = '0;
        if (act_c) begin
          buf_hour_d = bus.cur_hour;
          buf_min_d  = bus.cur_min;
          field_d    = 1'b0;
          state_d    = ST_EDIT_TIME;
        end else if (act_r) begin
          buf_hour_d = alarm_hour_q;
          buf_min_d  = alarm_min_q;
          field_d    = 1'b0;
          state_d    = ST_EDIT_ALARM;
        end else if (act_d) begin
          armed_d = ~armed_q;
        end else if (match_rise) begin
          state_d = ST_RING;
        end
      end

      ST_EDIT_TIME, ST_EDIT_ALARM: begin
        if (act_c) begin
          state_d = ST_RUN;
          if (state_q == ST_EDIT_TIME) begin
            load_d = 1'b1;
          end else begin
            alarm_hour_d = buf_hour_q;
            alarm_min_d  = buf_min_q;
            armed_d      = 1'b1;
          end
        end else begin
          if (act_l || act_r) field_d = ~field_q;
          if (act_u) begin
            if (!field_q) buf_hour_d = (buf_hour_q == 6'd23) ? 6'd0 : buf_hour_q + 6'd1;
            else          buf_min_d  = (buf_min_q  == 6'd59) ? 6'd0 : buf_min_q  + 6'd1;
          end
          if (act_d) begin
            if (!field_q) buf_hour_d = (buf_hour_q == 6'd0) ? 6'd23 : buf_hour_q - 6'd1;
            else          buf_min_d  = (buf_min_q  == 6'd0) ? 6'd59 : buf_min_q  - 6'd1;
          end
          if (any_edge) begin
            tmo_d = '0;
          end else if (sec_pulse) begin
            if (tmo_q == TW'(TIMEOUT_SEC - 1)) begin
              tmo_d   = '0;
              state_d = ST_RUN;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end
      end

      default: begin  // ST_RING
        if (any_edge) begin
          state_d = ST_RUN;
`ifdef SNOOZE_EN
          if (act_u) begin
            armed_d = 1'b1;
            if (snz_sum >= 7'd60) begin
              alarm_min_d  = 6'(snz_sum - 7'd60);
              alarm_hour_d = (alarm_hour_q == 6'd23) ? 6'd0 : alarm_hour_q + 6'd1;
            end else begin
              alarm_min_d = snz_sum[5:0];
            end
          end
`endif
        end else if (sec_pulse) begin
          if (ring_cnt_q == RW'(RING_SEC - 1)) begin
            ring_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end
    endcase

    // Counting pauses only while the live time is being edited.
    run_en_d = (state_d != ST_EDIT_TIME);
    if (state_d == ST_RUN) blink_d = 1'b0;
    else                   blink_d = blink_tick ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      btn_prev_q   <= 5'b11111;
      presc_q      <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      tmo_q        <= '0;
      ring_cnt_q   <= '0;
      buf_hour_q   <= '0;
      buf_min_q    <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      armed_q      <= 1'b0;
      field_q      <= 1'b0;
      load_q       <= 1'b0;
      run_en_q     <= 1'b1;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btn;
      presc_q      <= presc_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      tmo_q        <= tmo_d;
      ring_cnt_q   <= ring_cnt_d;
      buf_hour_q   <= buf_hour_d;
      buf_min_q    <= buf_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      armed_q      <= armed_d;
      field_q      <= field_d;
      load_q       <= load_d;
      run_en_q     <= run_en_d;
      match_q      <= match_d;
    end
  end

  assign bus.run_en      = run_en_q;
  assign bus.load        = load_q;
  assign bus.set_hour    = buf_hour_q;
  assign bus.set_min     = buf_min_q;
  assign bus.alarm_hour  = alarm_hour_q;
  assign bus.alarm_min   = alarm_min_q;
  assign bus.alarm_armed = armed_q;
  assign bus.ringing     = (state_q == ST_RING);
  assign bus.mode        = state_q;
  assign bus.field       = field_q;
  assign bus.blink       = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl : directed, table-driven bench for clock_mode_ctrl (CLK_HZ=8).
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_clock_mode_ctrl;
  localparam int HZ = 8;
  localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                         B_L = 5'b00010, B_R = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(.CLK_HZ(HZ), .TIMEOUT_SEC(30), .RING_SEC(60), .SNOOZE_MIN(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [4:0] btn;
    logic [1:0] mode;
    logic [5:0] hour;
    logic [5:0] min;
    logic       field;
    logic       run_en;
  } vec_t;

  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] b);
    {bus.btnC, bus.btnU, bus.btnD, bus.btnL, bus.btnR} = b;
  endtask

  // One-cycle press; returns at the release negedge, after the acting edge.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    set_btn(b);
    @(negedge clk);
    set_btn(5'b0);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = 6'(h);
    bus.cur_min  = 6'(m);
    bus.cur_sec  = 6'(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int loads;
    int toggles;
    logic prev_blink;

    set_btn(B_C);
    set_cur(12, 58, 10);

    // Reset with C held: no edge after release of reset.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mode", bus.mode, 0);
    chk("rst run_en", bus.run_en, 1);
    chk("rst load", bus.load, 0);
    chk("rst set_hour", bus.set_hour, 0);
    chk("rst set_min", bus.set_min, 0);
    chk("rst alarm", {bus.alarm_hour, bus.alarm_min}, 0);
    chk("rst armed", bus.alarm_armed, 0);
    chk("rst ringing", bus.ringing, 0);
    chk("rst field", bus.field, 0);
    chk("rst blink", bus.blink, 0);
    set_btn(5'b0);
    @(negedge clk);

    // Edit-time sequence table.
    vt.push_back('{B_C, 2'd1, 6'd12, 6'd58, 1'b0, 1'b0});
    for (int i = 1; i <= 12; i++)
      vt.push_back('{B_U, 2'd1, 6'((12 + i) % 24), 6'd58, 1'b0, 1'b0});
    vt.push_back('{B_D, 2'd1, 6'd23, 6'd58, 1'b0, 1'b0});
    vt.push_back('{B_U, 2'd1, 6'd0, 6'd58, 1'b0, 1'b0});
    vt.push_back('{B_R, 2'd1, 6'd0, 6'd58, 1'b1, 1'b0});
    vt.push_back('{B_D, 2'd1, 6'd0, 6'd57, 1'b1, 1'b0});
    vt.push_back('{B_U | B_D | B_L, 2'd1, 6'd0, 6'd58, 1'b1, 1'b0});
    vt.push_back('{B_D | B_L, 2'd1, 6'd0, 6'd57, 1'b1, 1'b0});
    vt.push_back('{B_L | B_R, 2'd1, 6'd0, 6'd57, 1'b0, 1'b0});
    vt.push_back('{B_R, 2'd1, 6'd0, 6'd57, 1'b1, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      press(vt[i].btn);
      chk($sformatf("v%0d mode", i), bus.mode, vt[i].mode);
      chk($sformatf("v%0d set_hour", i), bus.set_hour, vt[i].hour);
      chk($sformatf("v%0d set_min", i), bus.set_min, vt[i].min);
      chk($sformatf("v%0d field", i), bus.field, vt[i].field);
      chk($sformatf("v%0d run_en", i), bus.run_en, vt[i].run_en);
    end

    // Commit: load is a single-cycle strobe with the buffer on set_*.
    press(B_C);
    chk("commit load", bus.load, 1);
    chk("commit set", {bus.set_hour, bus.set_min}, {6'd0, 6'd57});
    chk("commit run_en", bus.run_en, 1);
    chk("commit mode", bus.mode, 0);
    @(negedge clk);
    chk("commit load width", bus.load, 0);

    // Alarm edit to 07:30.
    press(B_R);
    chk("alarm edit mode", bus.mode, 2);
    chk("alarm edit buf", {bus.set_hour, bus.set_min}, 0);
    chk("alarm edit run_en", bus.run_en, 1);
    repeat (7) press(B_U);
    press(B_R);
    repeat (30) press(B_U);
    chk("alarm buf", {bus.set_hour, bus.set_min}, {6'd7, 6'd30});
    press(B_C);
    chk("alarm store", {bus.alarm_hour, bus.alarm_min}, {6'd7, 6'd30});
    chk("alarm armed", bus.alarm_armed, 1);
    chk("alarm no load", bus.load, 0);
    chk("alarm mode", bus.mode, 0);

    // Match -> ring, dismiss with L.
    @(negedge clk);
    set_cur(7, 30, 0);
    @(negedge clk);
    chk("ring ringing", bus.ringing, 1);
    chk("ring mode", bus.mode, 3);
    press(B_L);
    chk("dismiss mode", bus.mode, 0);
    chk("dismiss ringing", bus.ringing, 0);
    chk("dismiss armed", bus.alarm_armed, 1);
    repeat (3) @(negedge clk);
    chk("no retrigger", bus.mode, 0);

    // Re-trigger and leave ringing until auto-dismiss.
    bus.cur_min = 6'd31;
    @(negedge clk);
    bus.cur_min = 6'd30;
    @(negedge clk);
    chk("ring2 ringing", bus.ringing, 1);
    n = 0;
    while (bus.ringing && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("ring auto-dismiss cycles ok", (n >= 472 && n <= 481), 1);
    chk("ring auto-dismiss mode", bus.mode, 0);
    chk("ring auto-dismiss armed", bus.alarm_armed, 1);

    // Edit timeout: no load, counting resumes.
    set_cur(10, 0, 0);
    press(B_C);
    chk("tmo enter mode", bus.mode, 1);
    chk("tmo enter run_en", bus.run_en, 0);
    n = 0;
    loads = 0;
    toggles = 0;
    prev_blink = bus.blink;
    while (bus.mode == 2'd1 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.load) loads++;
      if (bus.blink !== prev_blink) toggles++;
      prev_blink = bus.blink;
    end
    chk("tmo cycles ok", (n >= 232 && n <= 241), 1);
    chk("tmo no load", loads, 0);
    chk("tmo run_en", bus.run_en, 1);
    chk("tmo blink toggled", (toggles > 10), 1);
    chk("tmo blink run", bus.blink, 0);

    // Alarm 23:58 then U while ringing.
    press(B_R);
    repeat (8) press(B_D);
    press(B_R);
    repeat (28) press(B_U);
    press(B_C);
    chk("snz alarm set", {bus.alarm_hour, bus.alarm_min}, {6'd23, 6'd58});
    @(negedge clk);
    set_cur(23, 58, 0);
    @(negedge clk);
    chk("snz ringing", bus.ringing, 1);
    press(B_U);
    chk("snz mode", bus.mode, 0);
    chk("snz armed", bus.alarm_armed, 1);
`ifdef SNOOZE_EN
    chk("snz alarm", {bus.alarm_hour, bus.alarm_min}, {6'd0, 6'd3});
`else
    chk("snz alarm", {bus.alarm_hour, bus.alarm_min}, {6'd23, 6'd58});
`endif

    // Reset mid-edit discards the buffer.
    press(B_C);
    chk("rst-edit mode", bus.mode, 1);
    chk("rst-edit buf", {bus.set_hour, bus.set_min}, {6'd23, 6'd58});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst-edit mode after", bus.mode, 0);
    chk("rst-edit buf after", {bus.set_hour, bus.set_min}, 0);
    chk("rst-edit load", bus.load, 0);
    @(negedge clk);
    rst = 1'b0;
    loads = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.load) loads++;
    end
    chk("rst-edit no load", loads, 0);
    chk("rst-edit run_en", bus.run_en, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Mode and sequencing controller for the digital clock time datapath (hour/min/sec counters and BCD display path).
- Owns the five push-buttons: edits a time buffer and loads it into the datapath; stores and arms an alarm; drives the ring state.
- Pauses datapath counting while time is being edited.
- Provides display-select, edit-field and blink outputs for the 7-segment mux.

Parameters:
CLK_HZ, 10_000_000, clk cycles per second; internal 1 s prescaler terminal count is CLK_HZ-1
TIMEOUT_SEC, 30, seconds without a button edge before an edit is abandoned
RING_SEC, 60, seconds the alarm rings before auto-dismiss
SNOOZE_MIN, 5, minutes added to alarm time on snooze (SNOOZE_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btnC  in  1  enter/commit, debounced and synchronized level
btnU  in  1  increment, debounced and synchronized level
btnD  in  1  decrement / arm toggle, debounced and synchronized level
btnL  in  1  field select, debounced and synchronized level
btnR  in  1  field select / alarm-edit entry, debounced and synchronized level
cur_hour  in  6  datapath hour, 0..23
cur_min  in  6  datapath minute, 0..59
cur_sec  in  6  datapath second, 0..59
run_en  out  1  datapath count enable
load  out  1  one-cycle strobe: datapath takes set_hour/set_min and clears sec
set_hour  out  6  edit buffer hour; also the display value in edit modes
set_min  out  6  edit buffer minute
alarm_hour  out  6  stored alarm hour
alarm_min  out  6  stored alarm minute
alarm_armed  out  1  alarm enabled
ringing  out  1  alarm active
mode  out  2  0=RUN, 1=EDIT_TIME, 2=EDIT_ALARM, 3=RING
field  out  1  0=hour, 1=minute being edited
blink  out  1  flash enable for the selected field

Behaviour:
- Reset values: state RUN, run_en=1, load=0, set_*=0, alarm_*=0, alarm_armed=0, ringing=0, field=0, blink=0, prescaler=0, second counter=0.
- Button prev registers reset to 1, so a button held through reset produces no edge.
- Edge = btn & ~prev.
- At most one action per cycle. Priority: C > U > D > L > R. Lower-priority edges in the same cycle are dropped.
- Prescaler runs in all states. sec_pulse fires when the count reaches CLK_HZ-1.
- blink toggles every CLK_HZ/4 cycles in EDIT_* and RING. blink is forced to 0 in RUN.
- RUN:
  - C edge: copy cur_hour/cur_min to buffer, field=0, run_en=0 on the next cycle, go to EDIT_TIME.
  - R edge: copy alarm regs to buffer, field=0, go to EDIT_ALARM.
  - D edge: toggle alarm_armed.
  - Alarm match = armed & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0, registered. Its rising edge enters RING.
- EDIT_*:
  - L or R edge toggles field.
  - U edge increments the selected field: hour 23->0, minute 59->0, no carry into hour.
  - D edge decrements the selected field: hour 0->23, minute 0->59.
  - Any edge clears the timeout counter. sec_pulse increments it.
  - C edge in EDIT_TIME: load=1 for exactly one cycle with the buffer stable on set_*; run_en=1 in the same cycle; go to RUN.
  - C edge in EDIT_ALARM: write buffer to alarm regs, alarm_armed=1, go to RUN, no load.
  - Timeout reaching TIMEOUT_SEC: go to RUN; no load, no alarm change; run_en=1.
- RING:
  - ringing=1.
  - Any button edge: go to RUN, armed unchanged (except U under SNOOZE_EN).
  - RING_SEC sec_pulses elapsed: go to RUN.
  - The match edge cannot re-trigger within the same second because it is edge-based.
- The alarm is not evaluated outside RUN. A match that occurs during edit is missed and is not queued.
- rst mid-edit: buffer discarded, no load emitted, state RUN.

Optional Feature:
- Macro: SNOOZE_EN.
- Defined: U edge in RING adds SNOOZE_MIN to alarm_min, with carry into alarm_hour (59+5 -> min 4, hour+1, 23 wraps to 0). Then go to RUN with armed=1.
- Undefined: U in RING is an ordinary dismiss and the alarm regs are unchanged.

Test Plan:
All scenarios use CLK_HZ=8.
- Reset with btnC held high, then held -> no edge; mode=0, run_en=1, all outputs at their reset values.
- RUN, cur=12:58, pulse C -> mode=1, set=12:58, run_en=0. Then U x12 -> set_hour=0 (wrap). Then R, D -> set_min=57. Then C -> load high for exactly 1 cycle with 00:57, run_en=1, mode=0.
- RUN, pulse R; edit buffer to 07:30; pulse C -> alarm=07:30, armed=1. Drive cur=07:30:00 -> ringing=1 next cycle. Pulse L -> mode=0, armed stays 1.
- RING left alone -> auto-dismiss after 60 sec_pulses (480 cycles); ringing=0.
- EDIT_TIME with no buttons for 30 s (240 cycles) -> mode=0, no load pulse, run_en=1.
- SNOOZE_EN, alarm=23:58, ringing, pulse U -> alarm=00:03, mode=0, armed=1.
